// File: rtl/timekeep_pkg.sv
// Shared types and limits for the multimode timekeeping core.
package timekeep_pkg;

   typedef enum logic [1:0] {
      MODE_12H   = 2'd0,
      MODE_24H   = 2'd1,
      MODE_TIMER = 2'd2,
      MODE_SW    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      T_IDLE = 2'd0,
      T_RUN  = 2'd1,
      T_DONE = 2'd2
   } tmr_state_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2
   } sw_state_e;

   localparam int unsigned MS_MAX  = 999;
   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;
   localparam int unsigned HR_MAX  = 23;

   typedef struct packed {
      logic [4:0] hour;
      logic [5:0] min;
      logic [5:0] sec;
      logic [9:0] ms;
   } hms_t;

   // A set request is accepted only when every field is a legal time-of-day value.
   function automatic logic set_in_range(input logic [4:0] hour, input logic [5:0] min,
                                         input logic [5:0] sec);
      return (hour <= 5'(HR_MAX)) && (min <= 6'(MIN_MAX)) && (sec <= 6'(SEC_MAX));
   endfunction

endpackage

// File: rtl/hms_counter.sv
// H:M:S.ms cascade counter with up/down count, load (ms forced to 0) and clear.
module hms_counter
   import timekeep_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic up_i,
   input  logic load_i,
   input  logic clear_i,
   input  hms_t load_val_i,
   output hms_t cnt_o,
   output logic zero_o
);

   hms_t cnt_q, cnt_d;

   // Next count: clear beats load beats a counting step; both directions wrap over 24 h.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d    = load_val_i;
         cnt_d.ms = '0;
      end else if (en_i) begin
         if (up_i) begin
            if (cnt_q.ms == 10'(MS_MAX)) begin
               cnt_d.ms = '0;
               if (cnt_q.sec == 6'(SEC_MAX)) begin
                  cnt_d.sec = '0;
                  if (cnt_q.min == 6'(MIN_MAX)) begin
                     cnt_d.min  = '0;
                     cnt_d.hour = (cnt_q.hour == 5'(HR_MAX)) ? 5'd0 : cnt_q.hour + 5'd1;
                  end else begin
                     cnt_d.min = cnt_q.min + 6'd1;
                  end
               end else begin
                  cnt_d.sec = cnt_q.sec + 6'd1;
               end
            end else begin
               cnt_d.ms = cnt_q.ms + 10'd1;
            end
         end else begin
            if (cnt_q.ms == 10'd0) begin
               cnt_d.ms = 10'(MS_MAX);
               if (cnt_q.sec == 6'd0) begin
                  cnt_d.sec = 6'(SEC_MAX);
                  if (cnt_q.min == 6'd0) begin
                     cnt_d.min  = 6'(MIN_MAX);
                     cnt_d.hour = (cnt_q.hour == 5'd0) ? 5'(HR_MAX) : cnt_q.hour - 5'd1;
                  end else begin
                     cnt_d.min = cnt_q.min - 6'd1;
                  end
               end else begin
                  cnt_d.sec = cnt_q.sec - 6'd1;
               end
            end else begin
               cnt_d.ms = cnt_q.ms - 10'd1;
            end
         end
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/timekeep_multimode.sv
// Clock, countdown timer and stopwatch sharing a 1 kHz tick, with one registered display tuple.
module timekeep_multimode
   import timekeep_pkg::*;
#(
   parameter int unsigned CLK_HZ = 100_000_000,
   parameter int unsigned DIV    = CLK_HZ / 1000
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] mode_i,
   input  logic       start_stop_i,
   input  logic       lap_i,
   input  logic       clear_i,
   input  logic       set_i,
   input  logic [4:0] set_hour_i,
   input  logic [5:0] set_min_i,
   input  logic [5:0] set_sec_i,
   output logic [4:0] hour_o,
   output logic [5:0] min_o,
   output logic [5:0] sec_o,
   output logic [9:0] ms_o,
   output logic       pm_o,
   output logic       alarm_o,
   output logic       tick_o
);

   localparam int unsigned DivW = $clog2(DIV);

   logic [DivW-1:0] pre_q;
   logic            tick;

   assign tick = (pre_q == DivW'(DIV - 1));

   // Prescaler: 0..DIV-1, tick on the terminal count.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i)  pre_q <= '0;
      else if (tick) pre_q <= '0;
      else           pre_q <= pre_q + DivW'(1);
   end

   // Pulse routing: controls only reach the function chosen by mode_i.
   mode_e mode;
   hms_t  set_val;
   logic  set_ok;
   assign mode    = mode_e'(mode_i);
   assign set_val = '{hour: set_hour_i, min: set_min_i, sec: set_sec_i, ms: 10'd0};
   assign set_ok  = set_i && set_in_range(set_hour_i, set_min_i, set_sec_i);

   logic clk_load, tmr_load, tmr_clear, tmr_ss, sw_clear, sw_ss, sw_lap;
   assign clk_load  = set_ok && ((mode == MODE_12H) || (mode == MODE_24H));
   assign tmr_load  = set_ok && (mode == MODE_TIMER);
   assign tmr_clear = clear_i && (mode == MODE_TIMER);
   assign tmr_ss    = start_stop_i && (mode == MODE_TIMER);
   assign sw_clear  = clear_i && (mode == MODE_SW);
   assign sw_ss     = start_stop_i && (mode == MODE_SW);
   assign sw_lap    = lap_i && (mode == MODE_SW);

   tmr_state_e tmr_state_q;
   sw_state_e  sw_state_q;
   logic       alarm_q, lap_q;
   hms_t       snap_q;
   hms_t       clk_cnt, tmr_cnt, sw_cnt;
   logic       clk_zero, tmr_zero, sw_zero, tmr_last;

   hms_counter u_clock (
      .clk_i     (clk_i),
      .rst_ni    (reset_i),
      .en_i      (tick),
      .up_i      (1'b1),
      .load_i    (clk_load),
      .clear_i   (1'b0),
      .load_val_i(set_val),
      .cnt_o     (clk_cnt),
      .zero_o    (clk_zero)
   );

   hms_counter u_timer (
      .clk_i     (clk_i),
      .rst_ni    (reset_i),
      .en_i      (tick && (tmr_state_q == T_RUN)),
      .up_i      (1'b0),
      .load_i    (tmr_load),
      .clear_i   (tmr_clear),
      .load_val_i(set_val),
      .cnt_o     (tmr_cnt),
      .zero_o    (tmr_zero)
   );

   hms_counter u_stopwatch (
      .clk_i     (clk_i),
      .rst_ni    (reset_i),
      .en_i      (tick && (sw_state_q == S_RUN)),
      .up_i      (1'b1),
      .load_i    (1'b0),
      .clear_i   (sw_clear),
      .load_val_i(set_val),
      .cnt_o     (sw_cnt),
      .zero_o    (sw_zero)
   );

   logic unused_zero;
   assign unused_zero = clk_zero ^ sw_zero;

   // The decrement from 00:00:00.001 is the one that expires the timer.
   assign tmr_last = (tmr_cnt.hour == 5'd0) && (tmr_cnt.min == 6'd0) &&
                     (tmr_cnt.sec == 6'd0) && (tmr_cnt.ms == 10'd1);

   // Timer FSM with sticky alarm; set/clear override everything, including a tick.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         tmr_state_q <= T_IDLE;
         alarm_q     <= 1'b0;
      end else if (tmr_clear || tmr_load) begin
         tmr_state_q <= T_IDLE;
         alarm_q     <= 1'b0;
      end else begin
         case (tmr_state_q)
            T_IDLE: if (tmr_ss && !tmr_zero) tmr_state_q <= T_RUN;
            T_RUN: begin
               if (tick && tmr_last) begin
                  tmr_state_q <= T_DONE;
                  alarm_q     <= 1'b1;
               end else if (tmr_ss) begin
                  tmr_state_q <= T_IDLE;
               end
            end
            T_DONE:  tmr_state_q <= T_DONE;
            default: tmr_state_q <= T_IDLE;
         endcase
      end
   end

   // Stopwatch FSM and lap freeze; clear beats start/stop and lap in the same cycle.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sw_state_q <= S_IDLE;
         lap_q      <= 1'b0;
         snap_q     <= '0;
      end else if (sw_clear) begin
         sw_state_q <= S_IDLE;
         lap_q      <= 1'b0;
      end else begin
         case (sw_state_q)
            S_IDLE:  if (sw_ss) sw_state_q <= S_RUN;
            S_RUN:   if (sw_ss) sw_state_q <= S_PAUSE;
            S_PAUSE: if (sw_ss) sw_state_q <= S_RUN;
            default: sw_state_q <= S_IDLE;
         endcase
         if (sw_lap && (sw_state_q != S_IDLE)) begin
            lap_q <= !lap_q;
            if (!lap_q) snap_q <= sw_cnt;
         end
      end
   end

   hms_t disp_d, disp_q;
   logic pm_d, pm_q;

   // Display mux, including the 12 h hour mapping.
   always_comb begin
      disp_d = clk_cnt;
      pm_d   = 1'b0;
      case (mode)
         MODE_12H: begin
            pm_d = (clk_cnt.hour >= 5'd12);
            if (clk_cnt.hour == 5'd0)      disp_d.hour = 5'd12;
            else if (clk_cnt.hour > 5'd12) disp_d.hour = clk_cnt.hour - 5'd12;
         end
         MODE_24H:   disp_d = clk_cnt;
         MODE_TIMER: disp_d = tmr_cnt;
         MODE_SW:    disp_d = lap_q ? snap_q : sw_cnt;
         default:    disp_d = clk_cnt;
      endcase
   end

   // Output registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         disp_q <= '0;
         pm_q   <= 1'b0;
      end else begin
         disp_q <= disp_d;
         pm_q   <= pm_d;
      end
   end

   assign hour_o  = disp_q.hour;
   assign min_o   = disp_q.min;
   assign sec_o   = disp_q.sec;
   assign ms_o    = disp_q.ms;
   assign pm_o    = pm_q;
   assign alarm_o = alarm_q;
   assign tick_o  = tick;

endmodule

// File: tb/tb_timekeep_multimode.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor drains and compares.
module tb_timekeep_multimode;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] mode;
   logic       start_stop, lap, clear, set;
   logic [4:0] set_hour;
   logic [5:0] set_min, set_sec;
   logic [4:0] hour_o;
   logic [5:0] min_o, sec_o;
   logic [9:0] ms_o;
   logic       pm_o, alarm_o, tick_o;

   always #5 clk = ~clk;

   timekeep_multimode #(.CLK_HZ(4000)) dut (
      .clk_i       (clk),
      .reset_i     (reset_n),
      .mode_i      (mode),
      .start_stop_i(start_stop),
      .lap_i       (lap),
      .clear_i     (clear),
      .set_i       (set),
      .set_hour_i  (set_hour),
      .set_min_i   (set_min),
      .set_sec_i   (set_sec),
      .hour_o      (hour_o),
      .min_o       (min_o),
      .sec_o       (sec_o),
      .ms_o        (ms_o),
      .pm_o        (pm_o),
      .alarm_o     (alarm_o),
      .tick_o      (tick_o)
   );

   // kind 0: tuple+pm+alarm, 1: tick strobe, 2: expired wait (always a failure)
   typedef struct {
      int         kind;
      string      name;
      logic [4:0] h;
      logic [5:0] m;
      logic [5:0] s;
      logic [9:0] ms;
      logic       pm;
      logic       alarm;
      logic       tick;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   ntick = 0;

   function automatic void exp_full(input string name, input logic [4:0] h, input logic [5:0] m,
                                    input logic [5:0] s, input logic [9:0] ms, input logic pm,
                                    input logic alarm);
      exp_t e;
      e.kind = 0; e.name = name; e.h = h; e.m = m; e.s = s; e.ms = ms;
      e.pm = pm; e.alarm = alarm; e.tick = 1'b0;
      q.push_back(e);
   endfunction

   function automatic void exp_tick(input string name, input logic t);
      exp_t e;
      e.kind = 1; e.name = name; e.h = '0; e.m = '0; e.s = '0; e.ms = '0;
      e.pm = 1'b0; e.alarm = 1'b0; e.tick = t;
      q.push_back(e);
   endfunction

   function automatic void exp_timeout(input string name);
      exp_t e;
      e.kind = 2; e.name = name; e.h = '0; e.m = '0; e.s = '0; e.ms = '0;
      e.pm = 1'b0; e.alarm = 1'b0; e.tick = 1'b0;
      q.push_back(e);
   endfunction

   // Monitor: counts ticks and checks every queued expectation at the falling edge.
   initial begin
      logic [28:0] got, want;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (tick_o === 1'b1) ntick++;
         while (q.size() != 0) begin
            e = q.pop_front();
            n_cmp++;
            if (e.kind == 0) begin
               got  = {hour_o, min_o, sec_o, ms_o, pm_o, alarm_o};
               want = {e.h, e.m, e.s, e.ms, e.pm, e.alarm};
               if (got !== want) begin
                  n_err++;
                  $display("FAIL %s: got %0d:%0d:%0d.%0d pm=%b alarm=%b, expected %0d:%0d:%0d.%0d pm=%b alarm=%b",
                           e.name, hour_o, min_o, sec_o, ms_o, pm_o, alarm_o,
                           e.h, e.m, e.s, e.ms, e.pm, e.alarm);
               end
            end else if (e.kind == 1) begin
               if (tick_o !== e.tick) begin
                  n_err++;
                  $display("FAIL %s: tick_o got %b, expected %b", e.name, tick_o, e.tick);
               end
            end else begin
               n_err++;
               $display("FAIL %s: wait bound expired at tick count %0d", e.name, ntick);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Return inside a tick cycle.
   task automatic align();
      int budget;
      budget = 8;
      step(1);
      while (tick_o !== 1'b1 && budget > 0) begin
         step(1);
         budget--;
      end
      if (tick_o !== 1'b1) exp_timeout("align");
   endtask

   // Return in the cycle after the target tick (counter already advanced).
   task automatic wait_ticks_to(input int target, input string name);
      int budget;
      budget = (target - ntick) * 4 + 16;
      while (ntick < target && budget > 0) begin
         step(1);
         budget--;
      end
      if (ntick < target) exp_timeout(name);
   endtask

   // One-cycle set pulse; the load is visible in the counter on return.
   task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      set_hour = h; set_min = m; set_sec = s; set = 1'b1;
      step(1);
      set = 1'b0;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      step(1);
      start_stop = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      step(1);
      lap = 1'b0;
   endtask

   initial begin
      int base;
      reset_n = 1'b0; mode = 2'd0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; set = 1'b0;
      set_hour = '0; set_min = '0; set_sec = '0;

      // Reset, release, 12 h display and tick cadence.
      step(2);
      exp_full("in_reset", 0, 0, 0, 0, 0, 0);
      exp_tick("in_reset_tick", 1'b0);
      step(1);
      reset_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_tick($sformatf("tick_cycle_%0d", k), ((k % 4) == 3));
         if (k == 0) exp_full("release_cycle", 0, 0, 0, 0, 0, 0);
         if (k == 1) exp_full("12h_after_reset", 12, 0, 0, 0, 0, 0);
         step(1);
      end

      // Clock wrap from 23:59:59 over 1000 ticks, then 12 h view of midnight.
      mode = 2'd1;
      align();
      step(1);
      set_time(23, 59, 59);
      base = ntick;
      wait_ticks_to(base + 1000, "clock_wrap_wait");
      step(1);
      exp_full("clock_wrap_24h", 0, 0, 0, 0, 0, 0);
      mode = 2'd0;
      step(1);
      exp_full("clock_wrap_12h", 12, 0, 0, 0, 0, 0);

      // 13:05:00 in 12 h mode, then an out-of-range set that must be ignored.
      align();
      step(1);
      set_time(13, 5, 0);
      base = ntick;
      set_time(24, 5, 0);
      exp_full("set_13h_as_pm", 1, 5, 0, 0, 1, 0);
      step(1);
      exp_full("bad_hour_ignored", 1, 5, 0, 0, 1, 0);
      wait_ticks_to(base + 1000, "clock_continue_wait");
      step(1);
      exp_full("clock_continues", 1, 5, 1, 0, 1, 0);
      set_time(12, 0, 0);
      step(1);
      exp_full("noon_is_pm", 12, 0, 0, 0, 1, 0);

      // Set on a tick cycle: load wins, no increment from that tick.
      mode = 2'd1;
      align();
      exp_tick("set_on_tick_is_tick", 1'b1);
      set_time(10, 20, 30);
      step(1);
      exp_full("set_on_tick_loaded", 10, 20, 30, 0, 0, 0);
      step(4);
      exp_full("set_on_tick_next", 10, 20, 30, 1, 0, 0);

      // Timer: 2 s countdown, alarm one cycle after the terminal tick.
      mode = 2'd2;
      align();
      step(1);
      set_time(0, 0, 2);
      base = ntick;
      pulse_ss();
      wait_ticks_to(base + 1999, "timer_wait");
      step(3);
      exp_full("timer_terminal_tick", 0, 0, 0, 1, 0, 0);
      step(1);
      exp_full("timer_alarm_rise", 0, 0, 0, 1, 0, 1);
      step(1);
      exp_full("timer_zero_shown", 0, 0, 0, 0, 0, 1);
      pulse_ss();
      wait_ticks_to(ntick + 2, "timer_done_wait");
      step(1);
      exp_full("timer_done_ignores_start", 0, 0, 0, 0, 0, 1);
      clear = 1'b1;
      step(1);
      clear = 1'b0;
      exp_full("timer_clear_drops_alarm", 0, 0, 0, 0, 0, 0);
      pulse_ss();
      wait_ticks_to(ntick + 2, "timer_zero_start_wait");
      step(1);
      exp_full("timer_zero_no_start", 0, 0, 0, 0, 0, 0);

      // Stopwatch: lap freezes display at 0.500, second lap shows live 0.800.
      mode = 2'd3;
      align();
      step(1);
      base = ntick;
      pulse_ss();
      wait_ticks_to(base + 500, "sw_500_wait");
      pulse_lap();
      step(1);
      exp_full("sw_lap_snapshot", 0, 0, 0, 500, 0, 0);
      wait_ticks_to(base + 550, "sw_550_wait");
      step(1);
      exp_full("sw_lap_frozen", 0, 0, 0, 500, 0, 0);
      wait_ticks_to(base + 800, "sw_800_wait");
      pulse_lap();
      step(1);
      exp_full("sw_lap_release_800", 0, 0, 0, 800, 0, 0);
      step(4);
      exp_full("sw_live_801", 0, 0, 0, 801, 0, 0);

      // Clear together with start/stop while running: back to idle at zero.
      clear = 1'b1; start_stop = 1'b1;
      step(1);
      clear = 1'b0; start_stop = 1'b0;
      step(1);
      exp_full("sw_clear_wins", 0, 0, 0, 0, 0, 0);
      wait_ticks_to(ntick + 3, "sw_idle_wait");
      step(1);
      exp_full("sw_stays_idle", 0, 0, 0, 0, 0, 0);
      set_time(5, 5, 5);
      step(1);
      exp_full("sw_set_ignored", 0, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-operation.
      mode = 2'd0;
      step(2);
      reset_n = 1'b0;
      exp_full("async_reset_now", 0, 0, 0, 0, 0, 0);
      exp_tick("async_reset_tick", 1'b0);
      step(2);
      reset_n = 1'b1;
      step(1);
      exp_full("after_mid_reset_12h", 12, 0, 0, 0, 0, 0);
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
